// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// One operation in flight: grant/latch, capture result, respond, return to idle.
module alu_arbiter #(
    parameter int N = 32
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         REQ0,
    input  logic         REQ1,
    input  logic [3:0]   OP0,
    input  logic [3:0]   OP1,
    input  logic [N-1:0] A0,
    input  logic [N-1:0] B0,
    input  logic [N-1:0] A1,
    input  logic [N-1:0] B1,
    output logic         GNT0,
    output logic         GNT1,
    output logic         DONE0,
    output logic         DONE1,
    output logic [N-1:0] RESULT0,
    output logic [N-1:0] RESULT1,
    output logic         ZERO0,
    output logic         ZERO1,
    output logic [3:0]   ALU_OP,
    output logic [N-1:0] ALU_A,
    output logic [N-1:0] ALU_B,
    input  logic [N-1:0] ALU_RESULT,
    input  logic         ALU_ZERO,
    output logic         BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         win_q;
    logic         pick;
    logic         take;
    logic         capture;
    logic [3:0]   op_q;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;

    // win_q doubles as the round-robin pointer; it resets to 1 so requester 0
    // wins the first contested request.
    assign pick = (REQ0 && REQ1) ? ~win_q : REQ1;

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (REQ0 || REQ1) begin
                    take    = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                capture = 1'b1;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            win_q   <= 1'b1;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            GNT0    <= 1'b0;
            GNT1    <= 1'b0;
            DONE0   <= 1'b0;
            DONE1   <= 1'b0;
        end else begin
            state_q <= state_d;
            GNT0    <= take & ~pick;
            GNT1    <= take & pick;
            DONE0   <= capture & ~win_q;
            DONE1   <= capture & win_q;
            if (take) begin
                win_q <= pick;
                op_q  <= pick ? OP1 : OP0;
                a_q   <= pick ? A1 : A0;
                b_q   <= pick ? B1 : B0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            RESULT0 <= '0;
            RESULT1 <= '0;
            ZERO0   <= 1'b0;
            ZERO1   <= 1'b0;
        end else if (capture) begin
            if (win_q) begin
                RESULT1 <= ALU_RESULT;
                ZERO1   <= ALU_ZERO;
            end else begin
                RESULT0 <= ALU_RESULT;
                ZERO0   <= ALU_ZERO;
            end
        end
    end

    assign ALU_OP = op_q;
    assign ALU_A  = a_q;
    assign ALU_B  = b_q;
    assign BUSY   = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: table-driven transactions, scoreboard of expected
// completions, plus hand-written contention, reset-abort and pulse sequences.
module tb_alu_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        REQ0, REQ1;
    logic [3:0]  OP0, OP1;
    logic [31:0] A0, B0, A1, B1;
    logic        GNT0, GNT1, DONE0, DONE1;
    logic [31:0] RESULT0, RESULT1;
    logic        ZERO0, ZERO1;
    logic [3:0]  ALU_OP;
    logic [31:0] ALU_A, ALU_B;
    logic [31:0] ALU_RESULT;
    logic        ALU_ZERO;
    logic        BUSY;

    int vec_count = 0;
    int err_count = 0;

    always #5 CLK = ~CLK;

    assign ALU_RESULT = ALU_A + ALU_B;
    assign ALU_ZERO   = (ALU_RESULT == '0);

    alu_arbiter #(.N(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0(REQ0), .REQ1(REQ1), .OP0(OP0), .OP1(OP1),
        .A0(A0), .B0(B0), .A1(A1), .B1(B1),
        .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
        .RESULT0(RESULT0), .RESULT1(RESULT1), .ZERO0(ZERO0), .ZERO1(ZERO1),
        .ALU_OP(ALU_OP), .ALU_A(ALU_A), .ALU_B(ALU_B),
        .ALU_RESULT(ALU_RESULT), .ALU_ZERO(ALU_ZERO), .BUSY(BUSY)
    );

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        z;
    } exp_t;

    typedef struct {
        logic        r0;
        logic        r1;
        logic [3:0]  op;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] a1;
        logic [31:0] b1;
        int          win;
        logic [31:0] res;
        logic        z;
    } vec_t;

    exp_t        sbq[$];
    logic [31:0] held_res[2];
    logic        held_z[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Completion monitor: pops the scoreboard on every DONE pulse.
    always @(posedge CLK) begin
        #1;
        if (!RESET) begin
            if (GNT0 || GNT1) chk("gnt_exclusive", 64'(GNT0 & GNT1), 64'd0);
            if (DONE0 || DONE1) begin
                chk("done_exclusive", 64'(DONE0 & DONE1), 64'd0);
                chk("done_expected", 64'(sbq.size() != 0), 64'd1);
                if (sbq.size() != 0) begin
                    exp_t e;
                    int   id;
                    e  = sbq.pop_front();
                    id = DONE1 ? 1 : 0;
                    chk("done_id", 64'(id), 64'(e.id));
                    chk("result", 64'(id ? RESULT1 : RESULT0), 64'(e.res));
                    chk("zero", 64'(id ? ZERO1 : ZERO0), 64'(e.z));
                    held_res[id] = e.res;
                    held_z[id]   = e.z;
                    chk("other_result_held", 64'(id ? RESULT0 : RESULT1), 64'(held_res[1-id]));
                    chk("other_zero_held", 64'(id ? ZERO0 : ZERO1), 64'(held_z[1-id]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_model();
        sbq.delete();
        held_res[0] = '0; held_res[1] = '0;
        held_z[0]   = 1'b0; held_z[1] = 1'b0;
    endtask

    // Single-cycle request, then count pulses over a 6-cycle window.
    task automatic pulse_txn(input logic r0, input logic r1, input logic [31:0] a0,
                             input logic [31:0] b0, input logic [31:0] a1,
                             input logic [31:0] b1, input int exp_w);
        exp_t e;
        int n_g0, n_g1, n_d0, n_d1, n_busy;
        logic [31:0] sum;
        REQ0 = r0; REQ1 = r1; A0 = a0; B0 = b0; A1 = a1; B1 = b1;
        n_g0 = 0; n_g1 = 0; n_d0 = 0; n_d1 = 0; n_busy = 0;
        tick();
        sum   = (exp_w == 1) ? a1 + b1 : a0 + b0;
        e.id  = exp_w;
        e.res = sum;
        e.z   = (sum == '0);
        sbq.push_back(e);
        REQ0 = 1'b0; REQ1 = 1'b0;
        A0 = 32'h99; A1 = 32'h99;
        for (int k = 0; k < 6; k++) begin
            if (k != 0) tick();
            n_g0 += int'(GNT0); n_g1 += int'(GNT1);
            n_d0 += int'(DONE0); n_d1 += int'(DONE1);
            n_busy += int'(BUSY);
        end
        chk("pulse_gnt0_count", 64'(n_g0), 64'(exp_w == 0 ? 1 : 0));
        chk("pulse_gnt1_count", 64'(n_g1), 64'(exp_w == 1 ? 1 : 0));
        chk("pulse_done0_count", 64'(n_d0), 64'(exp_w == 0 ? 1 : 0));
        chk("pulse_done1_count", 64'(n_d1), 64'(exp_w == 1 ? 1 : 0));
        chk("pulse_busy_cycles", 64'(n_busy), 64'd2);
    endtask

    initial begin
        vec_t tbl[8];
        tbl[0] = '{1'b1, 1'b0, 4'h1, 32'h5, 32'h3, 32'h0, 32'h0, 0, 32'h8, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 4'h2, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h1, 1, 32'h0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 4'h3, 32'h1, 32'h2, 32'h7, 32'h9, 0, 32'h3, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 4'h4, 32'hA, 32'h14, 32'h0, 32'h0, 1, 32'h0, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 4'h5, 32'h0, 32'h0, 32'h4, 32'h4, 0, 32'h0, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 4'h6, 32'h0, 32'h0, 32'h64, 32'h17, 1, 32'h7B, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 4'hF, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 0, 32'h0, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 4'h8, 32'h1, 32'h1, 32'h2, 32'h2, 1, 32'h4, 1'b0};

        RESET = 1'b1;
        REQ0 = 1'b0; REQ1 = 1'b0; OP0 = '0; OP1 = '0;
        A0 = '0; B0 = '0; A1 = '0; B1 = '0;
        clear_model();
        tick(); tick();
        chk("reset_busy", 64'(BUSY), 64'd0);
        chk("reset_gnt", 64'({GNT0, GNT1}), 64'd0);
        chk("reset_done", 64'({DONE0, DONE1}), 64'd0);
        chk("reset_result0", 64'(RESULT0), 64'd0);
        chk("reset_result1", 64'(RESULT1), 64'd0);
        chk("reset_zero", 64'({ZERO0, ZERO1}), 64'd0);
        chk("reset_alu_ops", 64'({ALU_OP, ALU_A, ALU_B}), 64'd0);
        RESET = 1'b0;
        tick(); tick();
        chk("idle_no_req_busy", 64'(BUSY), 64'd0);
        chk("idle_no_req_alu_a", 64'(ALU_A), 64'd0);

        for (int i = 0; i < 8; i++) begin
            exp_t e;
            int   waited;
            logic got;
            REQ0 = tbl[i].r0; REQ1 = tbl[i].r1;
            OP0 = tbl[i].op; OP1 = tbl[i].op;
            A0 = tbl[i].a0; B0 = tbl[i].b0; A1 = tbl[i].a1; B1 = tbl[i].b1;
            tick();
            chk("vec_gnt0", 64'(GNT0), 64'(tbl[i].win == 0));
            chk("vec_gnt1", 64'(GNT1), 64'(tbl[i].win == 1));
            chk("vec_busy", 64'(BUSY), 64'd1);
            chk("vec_alu_op", 64'(ALU_OP), 64'(tbl[i].op));
            chk("vec_alu_a", 64'(ALU_A), 64'(tbl[i].win == 1 ? tbl[i].a1 : tbl[i].a0));
            e.id = tbl[i].win; e.res = tbl[i].res; e.z = tbl[i].z;
            sbq.push_back(e);
            REQ0 = 1'b0; REQ1 = 1'b0;
            OP0 = 4'($urandom); OP1 = 4'($urandom);
            A0 = $urandom; B0 = $urandom; A1 = $urandom; B1 = $urandom;
            got = 1'b0; waited = 0;
            for (int k = 0; k < 4; k++) begin
                tick();
                waited = k;
                if (DONE0 || DONE1) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("vec_done_seen", 64'(got), 64'd1);
            chk("vec_done_latency", 64'(waited), 64'd0);
            chk("vec_alu_op_held", 64'(ALU_OP), 64'(tbl[i].op));
            tick();
            chk("vec_idle_busy", 64'(BUSY), 64'd0);
            chk("vec_idle_done", 64'({DONE0, DONE1}), 64'd0);
        end

        // Both requesters held: grants alternate 0,1,0,1 every third cycle.
        REQ0 = 1'b1; REQ1 = 1'b1;
        A0 = 32'h3; B0 = 32'h4; A1 = 32'h5; B1 = 32'h5;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("rr_gnt0", 64'(GNT0), 64'((k % 6) == 0));
            chk("rr_gnt1", 64'(GNT1), 64'((k % 6) == 3));
            chk("rr_busy", 64'(BUSY), 64'((k % 3) != 2));
            if (GNT0 || GNT1) begin
                exp_t e;
                e.id  = GNT1 ? 1 : 0;
                e.res = GNT1 ? 32'hA : 32'h7;
                e.z   = 1'b0;
                sbq.push_back(e);
            end
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
        tick();
        chk("rr_drain_busy", 64'(BUSY), 64'd0);

        // Reset while the operation is in EXEC: everything clears, no DONE.
        REQ0 = 1'b1; A0 = 32'h10; B0 = 32'h20;
        tick();
        chk("abort_gnt0", 64'(GNT0), 64'd1);
        REQ0 = 1'b0; A0 = 32'h99;
        #2 RESET = 1'b1;
        #1;
        chk("abort_busy", 64'(BUSY), 64'd0);
        chk("abort_gnt", 64'({GNT0, GNT1}), 64'd0);
        chk("abort_results", 64'({RESULT0, RESULT1}), 64'd0);
        chk("abort_zero", 64'({ZERO0, ZERO1}), 64'd0);
        chk("abort_alu_ops", 64'({ALU_OP, ALU_A, ALU_B}), 64'd0);
        clear_model();
        tick();
        RESET = 1'b0;
        begin
            int n_done;
            n_done = 0;
            for (int k = 0; k < 3; k++) begin
                tick();
                n_done += int'(DONE0) + int'(DONE1);
            end
            chk("abort_no_done", 64'(n_done), 64'd0);
        end

        // Pointer is back at requester 0; operand change in EXEC is ignored.
        pulse_txn(1'b1, 1'b1, 32'h10, 32'h20, 32'h7, 32'h7, 0);
        pulse_txn(1'b1, 1'b0, 32'h40, 32'h2, 32'h0, 32'h0, 0);
        pulse_txn(1'b1, 1'b1, 32'h1, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);

        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
